// File: rtl/uart_tx_if.sv
// Parallel-word handshake between a word producer and the UART transmitter.
// Producer (master) drives tx_data/tx_valid; transmitter (slave) drives tx_ready/busy.
interface uart_tx_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic                 busy;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready,
    input  busy
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready,
    output busy
  );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start, DATA_BITS data (LSB first), parity when UART_TX_PARITY_EN is defined, STOP_BITS stop.
// Latency: tx falls on the accept edge; a frame lasts (1+DATA_BITS+P+STOP_BITS)*OVERSAMPLE sample ticks.
// Backpressure: tx_ready is high only in IDLE; tx_valid while busy is ignored and nothing is queued.
module uart_tx #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     sample_tick,
  uart_tx_if.slave bus,
  output logic     tx
);

  localparam int CNT_W = $clog2(OVERSAMPLE * STOP_BITS);
  localparam int IDX_W = $clog2(DATA_BITS + 1);

  localparam logic [CNT_W-1:0] CNT_BIT_LAST  = CNT_W'(OVERSAMPLE - 1);
  localparam logic [CNT_W-1:0] CNT_STOP_LAST = CNT_W'(OVERSAMPLE * STOP_BITS - 1);
  localparam logic [IDX_W-1:0] IDX_LAST      = IDX_W'(DATA_BITS - 1);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx: DATA_BITS must be in 5..9");
  end
  if (OVERSAMPLE < 2) begin : g_bad_oversample
    $error("uart_tx: OVERSAMPLE must be at least 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_tx: STOP_BITS must be 1 or 2");
  end
  if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity_odd
    $error("uart_tx: PARITY_ODD must be 0 or 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t               r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [IDX_W-1:0]     r_bit;
  logic [DATA_BITS-1:0] r_sh;
  logic                 r_tx;
  logic                 r_rdy;
  logic                 r_busy;
  logic                 w_bit_end;

`ifdef UART_TX_PARITY_EN
  localparam logic PAR_SENSE = 1'(PARITY_ODD);
  logic r_par;
`endif

  // Both stop bits share one STOP state, so its period is STOP_BITS bit-times long.
  assign w_bit_end = sample_tick &&
                     (r_cnt == ((r_state == S_STOP) ? CNT_STOP_LAST : CNT_BIT_LAST));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_sh    <= '0;
      r_tx    <= 1'b1;
      r_rdy   <= 1'b1;
      r_busy  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          // Ticks here are ignored, so a tick on the accept edge never counts.
          if (bus.tx_valid) begin
            r_sh    <= bus.tx_data;
`ifdef UART_TX_PARITY_EN
            r_par   <= (^bus.tx_data) ^ PAR_SENSE;
`endif
            r_tx    <= 1'b0;
            r_rdy   <= 1'b0;
            r_busy  <= 1'b1;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_state <= S_START;
          end
        end

        default: begin
          if (sample_tick && !w_bit_end) begin
            r_cnt <= r_cnt + 1'b1;
          end else if (w_bit_end) begin
            r_cnt <= '0;
            case (r_state)
              S_START: begin
                r_tx    <= r_sh[0];
                r_state <= S_DATA;
              end

              S_DATA: begin
                if (r_bit == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
                  r_tx    <= r_par;
                  r_state <= S_PARITY;
`else
                  r_tx    <= 1'b1;
                  r_state <= S_STOP;
`endif
                end else begin
                  r_bit <= r_bit + 1'b1;
                  r_sh  <= r_sh >> 1;
                  r_tx  <= r_sh[1];
                end
              end

`ifdef UART_TX_PARITY_EN
              S_PARITY: begin
                r_tx    <= 1'b1;
                r_state <= S_STOP;
              end
`endif

              S_STOP: begin
                r_tx    <= 1'b1;
                r_rdy   <= 1'b1;
                r_busy  <= 1'b0;
                r_state <= S_IDLE;
              end

              default: begin
                r_tx    <= 1'b1;
                r_rdy   <= 1'b1;
                r_busy  <= 1'b0;
                r_state <= S_IDLE;
              end
            endcase
          end
        end
      endcase
    end
  end

  assign tx           = r_tx;
  assign bus.tx_ready = r_rdy;
  assign bus.busy     = r_busy;

endmodule
